// File: rtl/fft_pkg.sv
// Shared FFT front-end constants: frame geometry, sample widths and sink bus widths
// used by fft_frame_feeder, fft_control and fft_calfre.
package fft_pkg;

  localparam int FFT_FRAME_LEN = 256;
  localparam int FFT_IW        = 16;
  localparam int FFT_OW        = 18;

  localparam int FFT_SINK_REAL_W = FFT_OW;
  localparam int FFT_SINK_IMAG_W = FFT_OW;

  typedef enum logic {
    WR_FILL,
    WR_WAIT
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_LOAD,
    RD_STREAM
  } rd_state_t;

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two FRAME_LEN x IW banks behind one write port and one registered read port.
// Read data only changes when i_rd_en is high, so it doubles as the sink data holding register.
module fft_pingpong_ram import fft_pkg::*; #(
  parameter int FRAME_LEN = FFT_FRAME_LEN,
  parameter int IW        = FFT_IW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_wr_en,
  input  logic                         i_wr_bank,
  input  logic [$clog2(FRAME_LEN)-1:0] i_wr_addr,
  input  logic [IW-1:0]                i_wr_data,
  input  logic                         i_rd_en,
  input  logic                         i_rd_bank,
  input  logic [$clog2(FRAME_LEN)-1:0] i_rd_addr,
  output logic [IW-1:0]                o_rd_data
);

  logic [IW-1:0] r_mem [0:2*FRAME_LEN-1];
  logic [IW-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[{i_rd_bank, i_rd_addr}];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fft_frame_feeder.sv
// Ping-pong frame buffer: fills one bank from the sample stream while the other bank
// is replayed to the FFT sink as a sop/eop packet under valid/ready backpressure.
module fft_frame_feeder import fft_pkg::*; #(
  parameter int FRAME_LEN = FFT_FRAME_LEN,
  parameter int IW        = FFT_IW,
  parameter int OW        = FFT_OW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  input  logic [IW-1:0] i_sample,
  output logic          o_sink_valid,
  output logic [OW-1:0] o_sink_real,
  output logic [OW-1:0] o_sink_imag,
  output logic          o_sink_sop,
  output logic          o_sink_eop,
  input  logic          i_sink_ready,
  output logic          o_overflow
);

  localparam int AW = $clog2(FRAME_LEN);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

  wr_state_t     r_wr_state;
  wr_state_t     w_wr_state_nxt;
  logic          r_wr_bank;
  logic          w_wr_bank_nxt;
  logic [AW-1:0] r_wr_addr;
  logic [AW-1:0] w_wr_addr_nxt;
  logic          w_wr_en;
  logic          w_other_free;
  logic          w_ovf;
  logic [1:0]    r_full;
  logic [1:0]    w_full_set;
  logic [1:0]    w_full_clr;
  logic          r_overflow;

  rd_state_t     r_rd_state;
  rd_state_t     w_rd_state_nxt;
  logic          r_rd_bank;
  logic [AW-1:0] r_rd_addr;
  logic [AW-1:0] w_rd_addr;
  logic          w_rd_en;
  logic          w_rd_done;
  logic          w_accept;
  logic          r_sink_valid;
  logic          r_sink_sop;
  logic          r_sink_eop;
  logic [IW-1:0] w_rd_data;

  assign w_accept = r_sink_valid && i_sink_ready;

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_bank_nxt  = r_wr_bank;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_en        = 1'b0;
    w_full_set     = 2'b00;
    w_ovf          = 1'b0;
    // A bank whose eop is being accepted this very cycle counts as free.
    w_other_free   = !r_full[~r_wr_bank] || (w_rd_done && (r_rd_bank != r_wr_bank));
    case (r_wr_state)
      WR_FILL: begin
        if (i_valid) begin
          w_wr_en       = 1'b1;
          w_wr_addr_nxt = r_wr_addr + 1'b1;
          if (r_wr_addr == LAST_ADDR) begin
            w_full_set[r_wr_bank] = 1'b1;
            if (w_other_free) begin
              w_wr_bank_nxt = ~r_wr_bank;
            end else begin
              w_wr_state_nxt = WR_WAIT;
            end
          end
        end
      end
      WR_WAIT: begin
        w_ovf = i_valid;
        if (!r_full[~r_wr_bank]) begin
          w_wr_bank_nxt  = ~r_wr_bank;
          w_wr_state_nxt = WR_FILL;
        end
      end
      default: w_wr_state_nxt = WR_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_state <= WR_FILL;
      r_wr_bank  <= 1'b0;
      r_wr_addr  <= '0;
      r_full     <= 2'b00;
      r_overflow <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_bank  <= w_wr_bank_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_full     <= (r_full | w_full_set) & ~w_full_clr;
      r_overflow <= w_ovf;
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_en        = 1'b0;
    w_rd_addr      = r_rd_addr;
    w_rd_done      = 1'b0;
    w_full_clr     = 2'b00;
    case (r_rd_state)
      RD_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_rd_state_nxt = RD_LOAD;
        end
      end
      RD_LOAD: begin
        w_rd_en        = 1'b1;
        w_rd_addr      = '0;
        w_rd_state_nxt = RD_STREAM;
      end
      RD_STREAM: begin
        if (w_accept) begin
          if (r_rd_addr == LAST_ADDR) begin
            w_rd_done              = 1'b1;
            w_full_clr[r_rd_bank]  = 1'b1;
            w_rd_state_nxt         = RD_IDLE;
          end else begin
            // Prefetch the next word on acceptance to keep the stream bubble-free.
            w_rd_en   = 1'b1;
            w_rd_addr = r_rd_addr + 1'b1;
          end
        end
      end
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_state   <= RD_IDLE;
      r_rd_bank    <= 1'b0;
      r_rd_addr    <= '0;
      r_sink_valid <= 1'b0;
      r_sink_sop   <= 1'b0;
      r_sink_eop   <= 1'b0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      if (w_rd_en) begin
        r_rd_addr <= w_rd_addr;
      end
      if (w_rd_done) begin
        r_rd_bank <= ~r_rd_bank;
      end
      if (r_rd_state == RD_LOAD) begin
        r_sink_valid <= 1'b1;
        r_sink_sop   <= 1'b1;
        r_sink_eop   <= (FRAME_LEN == 1);
      end else if (w_rd_done) begin
        r_sink_valid <= 1'b0;
        r_sink_sop   <= 1'b0;
        r_sink_eop   <= 1'b0;
      end else if (w_rd_en) begin
        r_sink_sop <= 1'b0;
        r_sink_eop <= (w_rd_addr == LAST_ADDR);
      end
    end
  end

  fft_pingpong_ram #(
    .FRAME_LEN(FRAME_LEN),
    .IW       (IW)
  ) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_en  (w_wr_en),
    .i_wr_bank(r_wr_bank),
    .i_wr_addr(r_wr_addr),
    .i_wr_data(i_sample),
    .i_rd_en  (w_rd_en),
    .i_rd_bank(r_rd_bank),
    .i_rd_addr(w_rd_addr),
    .o_rd_data(w_rd_data)
  );

  assign o_sink_valid = r_sink_valid;
  assign o_sink_sop   = r_sink_sop;
  assign o_sink_eop   = r_sink_eop;
  assign o_sink_real  = OW'(signed'(w_rd_data));
  assign o_sink_imag  = '0;
  assign o_overflow   = r_overflow;

endmodule

// File: doc/fft_frame_feeder.md
# fft_frame_feeder

Ping-pong frame buffer that sits directly upstream of the FFT core. It collects a continuous stream of 16-bit signed audio samples from the voice capture path into 256-sample frames. It then streams each complete frame into the FFT sink interface as an Avalon-ST packet with sop/eop and backpressure. Imaginary input is zero; real input is the sign-extended sample.

## Interface

Parameters:
- FRAME_LEN, 256: samples per FFT frame; power of two.
- IW, 16: input sample width, signed.
- OW, 18: FFT sink data width; must be ≥ IW.

Ports:
- clk  in  1  single clock; all logic is clocked on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- i_valid  in  1  i_sample is valid this cycle. There is no ready back to the source.
- i_sample  in  IW  signed PCM sample.
- o_sink_valid  out  OW-independent 1  FFT sink valid.
- o_sink_real  out  OW  sign-extended sample.
- o_sink_imag  out  OW  constant 0.
- o_sink_sop  out  1  first sample of frame.
- o_sink_eop  out  1  last sample of frame.
- i_sink_ready  in  1  FFT accepts the beat when o_sink_valid & i_sink_ready.
- o_overflow  out  1  one-cycle pulse per input sample dropped.

## Operation

- Storage is two banks, each FRAME_LEN×IW. Each bank has a full flag.
- Writer FSM:
  - States: FILL, WAIT.
  - FILL: each i_valid writes i_sample to wr_bank[wr_addr], then wr_addr++.
  - Writing address FRAME_LEN-1 sets full[wr_bank] and wraps wr_addr to 0.
  - On that write, if the other bank is free (including a bank freed in the same cycle), wr_bank toggles and the FSM stays in FILL. Otherwise it goes to WAIT.
  - WAIT: i_valid samples are discarded, and o_overflow pulses for each.
  - WAIT exits when the other bank's full flag clears; wr_bank toggles and the FSM returns to FILL. A sample arriving in that exit cycle is dropped.
- Reader FSM:
  - States: IDLE, LOAD, STREAM.
  - IDLE: when full[rd_bank] is set, go to LOAD. LOAD issues the read of address 0.
  - STREAM presents one sample per beat.
  - o_sink_sop is asserted on address 0; o_sink_eop on address FRAME_LEN-1.
  - On eop acceptance: clear full[rd_bank], toggle rd_bank, return to IDLE.
- Data path:
  - o_sink_real = {{(OW-IW){s[IW-1]}}, s}.
  - o_sink_imag = 0.
- Ordering: frames leave in arrival order; samples within a frame leave in arrival order. There is no reordering or windowing.

## Timing

- Reset values: o_sink_valid=0, o_sink_sop=0, o_sink_eop=0, o_sink_real=0, o_sink_imag=0, o_overflow=0. Both full flags are 0, wr_bank=rd_bank=0, both addresses are 0, both FSMs are FILL/IDLE.
- Frame latency: the full flag is set at edge N, when the last sample is written. With the reader IDLE, o_sink_valid and o_sink_sop go high at edge N+2 (one cycle FSM, one cycle RAM read).
- Throughput: with i_sink_ready held high, FRAME_LEN consecutive valid beats are emitted with no bubbles. The RAM read is prefetched using the next address on acceptance.
- Backpressure: while o_sink_valid & !i_sink_ready, all o_sink_* outputs hold stable. o_sink_valid never drops mid-frame.
- Between frames: o_sink_valid is low for at least 2 cycles (IDLE, LOAD).
- Same-cycle collision: if eop is accepted in the same cycle the writer writes its last address, the writer sees the bank as free, toggles, and drops nothing.
- A read bank is never written; the writer only targets a bank whose full flag is 0.
- Reset mid-operation: rst_n low at any edge returns all outputs to reset values at that edge. The partial frame is discarded, and the next packet starts with sop from fresh data.

## Structure

- Shared package fft_pkg holds FRAME_LEN, IW, OW, and the FFT sink width constants used by fft_control and fft_calfre.
- One sub-module, fft_pingpong_ram: two banks, 1 write port, 1 registered read port, inferred block RAM.
- FSMs, flags, and sink output registers live in the top module.

## Test plan

- Ramp, ready high: reset, feed 256 samples 0..255 with i_valid=1.
  - sop appears 2 cycles after the last write, with real=0.
  - 256 contiguous beats follow, ending in eop with real=255.
  - imag=0 throughout; no overflow.
- Sign extension: feed 16'h8000 and 16'h7FFF at addresses 0 and 1. Required: real=18'h38000, then 18'h07FFF.
- Backpressure: i_sink_ready follows a pseudo-random 50% pattern. Required: all 256 samples arrive in order, and outputs are stable on every valid & !ready cycle.
- Overflow: ready low, feed 600 samples 0..599.
  - Samples 512..599 produce 88 o_overflow pulses.
  - Releasing ready yields the frame 0..255, then 256..511.
  - The writer then resumes filling.
- Collision: align ready so that eop of frame k is accepted on the same edge that sample 255 of frame k+1 is written. Required: zero overflow pulses, and frame k+1 streams normally.
- Mid-frame reset: assert rst_n=0 while beat 100 is presented. Required: all outputs are 0 at the next edge. After refill, the next packet starts with sop on new data.
